// File: rtl/p4_router_ingress_arbiter.sv
// Frame-level round-robin merge of NUM_PORTS ingress AXIS streams, tagging m_tid and truncating overlong frames.
// Optional: define P4_ROUTER_ING_ARB_OUTPUT_REG_EN for a 2-entry skid slice on the m_* outputs.
module p4_router_ingress_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int DATA_BYTES      = 8,
   parameter int PORT_ID_WIDTH   = 4,
   parameter int MAX_FRAME_WORDS = 256,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                               clk,
   input  logic                               aresetn,
   input  logic [NUM_PORTS-1:0]               s_tvalid,
   output logic [NUM_PORTS-1:0]               s_tready,
   input  logic [NUM_PORTS*DATA_BYTES*8-1:0]  s_tdata,
   input  logic [NUM_PORTS*DATA_BYTES-1:0]    s_tkeep,
   input  logic [NUM_PORTS-1:0]               s_tlast,
   output logic                               m_tvalid,
   input  logic                               m_tready,
   output logic [DATA_BYTES*8-1:0]            m_tdata,
   output logic [DATA_BYTES-1:0]              m_tkeep,
   output logic                               m_tlast,
   output logic [PORT_ID_WIDTH-1:0]           m_tid,
   output logic                               m_trunc,
   output logic [NUM_PORTS-1:0]               trunc_stb,
   output logic [CNT_WIDTH-1:0]               trunc_count
);

   localparam int DW = DATA_BYTES * 8;
   localparam int PW = $clog2(NUM_PORTS);
   localparam int BW = $clog2(MAX_FRAME_WORDS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PASS  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]               state_reg;
   logic [PW-1:0]            grant_reg;
   logic [PW-1:0]            last_grant_reg;
   logic [PW-1:0]            next_grant;
   logic                     grant_found;
   logic [BW-1:0]            beat_cnt_reg;
   logic [NUM_PORTS-1:0]     trunc_stb_reg;
   logic [CNT_WIDTH-1:0]     trunc_count_reg;
   logic [PORT_ID_WIDTH-1:0] tid_ext;

   logic                     g_valid;
   logic                     g_last;
   logic [DW-1:0]            g_data;
   logic [DATA_BYTES-1:0]    g_keep;
   logic                     trunc_hit;
   logic                     c_valid;
   logic                     c_ready;
   logic                     c_last;
   logic                     c_trunc;
   logic                     c_fire;
   logic                     port_ready;

   assign g_valid = s_tvalid[grant_reg];
   assign g_last  = s_tlast[grant_reg];
   assign g_data  = s_tdata[int'(grant_reg)*DW +: DW];
   assign g_keep  = s_tkeep[int'(grant_reg)*DATA_BYTES +: DATA_BYTES];

   // The beat carrying the last permitted word becomes the frame end unless the source already ends there.
   assign trunc_hit = (beat_cnt_reg == BW'(MAX_FRAME_WORDS - 1)) && !g_last;
   assign c_last    = g_last || trunc_hit;
   assign c_trunc   = trunc_hit;
   assign c_fire    = c_valid && c_ready;

   always_comb begin
      tid_ext = '0;
      tid_ext[PW-1:0] = grant_reg;
   end

   // Round-robin scan starting just after the previous winner.
   always_comb begin
      next_grant  = last_grant_reg;
      grant_found = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         if (!grant_found && s_tvalid[(int'(last_grant_reg) + i) % NUM_PORTS]) begin
            next_grant  = PW'((int'(last_grant_reg) + i) % NUM_PORTS);
            grant_found = 1'b1;
         end
      end
   end

   always_comb begin
      c_valid    = 1'b0;
      port_ready = 1'b0;
      case (state_reg)
         ST_PASS: begin
            c_valid    = g_valid;
            port_ready = c_ready;
         end
         ST_DRAIN: port_ready = 1'b1;
         default: ;
      endcase
   end

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign s_tready[gi] = (grant_reg == PW'(gi)) && port_ready;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg       <= ST_IDLE;
         grant_reg       <= '0;
         last_grant_reg  <= PW'(NUM_PORTS - 1);
         beat_cnt_reg    <= '0;
         trunc_stb_reg   <= '0;
         trunc_count_reg <= '0;
      end else begin
         trunc_stb_reg <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (grant_found) begin
                  grant_reg      <= next_grant;
                  last_grant_reg <= next_grant;
                  state_reg      <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (c_fire) begin
                  if (g_last) begin
                     state_reg    <= ST_IDLE;
                     beat_cnt_reg <= '0;
                  end else if (trunc_hit) begin
                     state_reg                <= ST_DRAIN;
                     beat_cnt_reg             <= '0;
                     trunc_stb_reg[grant_reg] <= 1'b1;
                     if (trunc_count_reg != '1) begin
                        trunc_count_reg <= trunc_count_reg + 1'b1;
                     end
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (g_valid && g_last) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign trunc_stb   = trunc_stb_reg;
   assign trunc_count = trunc_count_reg;

`ifdef P4_ROUTER_ING_ARB_OUTPUT_REG_EN
   localparam int SW = DW + DATA_BYTES + 2 + PORT_ID_WIDTH;

   logic [SW-1:0] c_word;
   logic [SW-1:0] out_word_reg;
   logic [SW-1:0] skid_word_reg;
   logic          out_valid_reg;
   logic          skid_valid_reg;

   assign c_word  = {g_data, g_keep, c_last, c_trunc, tid_ext};
   // Ready comes from slice occupancy only, so the input side never sees m_tready combinationally.
   assign c_ready = !skid_valid_reg;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
         out_word_reg   <= '0;
         skid_word_reg  <= '0;
      end else if (!out_valid_reg || m_tready) begin
         if (skid_valid_reg) begin
            out_word_reg   <= skid_word_reg;
            out_valid_reg  <= 1'b1;
            skid_valid_reg <= 1'b0;
         end else begin
            if (c_fire) begin
               out_word_reg <= c_word;
            end
            out_valid_reg <= c_fire;
         end
      end else if (c_fire) begin
         skid_word_reg  <= c_word;
         skid_valid_reg <= 1'b1;
      end
   end

   assign m_tvalid = out_valid_reg;
   assign {m_tdata, m_tkeep, m_tlast, m_trunc, m_tid} = out_word_reg;
`else
   assign c_ready  = m_tready;
   assign m_tvalid = c_valid;
   assign m_tdata  = g_data;
   assign m_tkeep  = g_keep;
   assign m_tlast  = (state_reg == ST_PASS) && c_last;
   assign m_trunc  = (state_reg == ST_PASS) && c_trunc;
   assign m_tid    = tid_ext;
`endif

endmodule

// File: tb/tb_p4_router_ingress_arbiter.sv
// Self-checking bench for p4_router_ingress_arbiter: per-port frame model plus directed round-robin,
// truncation, randomised-traffic and reset checks.
module tb_p4_router_ingress_arbiter;

   localparam int NP   = 4;
   localparam int DB   = 8;
   localparam int DW   = DB * 8;
   localparam int PID  = 4;
   localparam int MAXW = 8;
   localparam int CW   = 32;

   typedef struct packed {
      logic [31:0] id;
      logic [31:0] len;
   } frame_t;

   logic              clk = 1'b0;
   logic              aresetn;
   logic [NP-1:0]     s_tvalid;
   logic [NP-1:0]     s_tready;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*DB-1:0]  s_tkeep;
   logic [NP-1:0]     s_tlast;
   logic              m_tvalid;
   logic              m_tready;
   logic [DW-1:0]     m_tdata;
   logic [DB-1:0]     m_tkeep;
   logic              m_tlast;
   logic [PID-1:0]    m_tid;
   logic              m_trunc;
   logic [NP-1:0]     trunc_stb;
   logic [CW-1:0]     trunc_count;

   always #5 clk = ~clk;

   p4_router_ingress_arbiter #(
      .NUM_PORTS(NP), .DATA_BYTES(DB), .PORT_ID_WIDTH(PID),
      .MAX_FRAME_WORDS(MAXW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .aresetn(aresetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_trunc(m_trunc),
      .trunc_stb(trunc_stb), .trunc_count(trunc_count)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int gap_pct = 0;
   int rdy_pct = 100;

   frame_t drv_q[NP][$];
   frame_t exp_q[NP][$];
   bit     drv_active[NP];
   int     drv_id[NP];
   int     drv_len[NP];
   int     drv_beat[NP];
   int     next_id[NP];
   int     exp_stb[NP];
   int     stb_cnt[NP];
   int     exp_tc = 0;

   bit in_frame = 1'b0;
   int cur_tid  = 0;
   int cur_beat = 0;
   int beats_seen  = 0;
   int frames_seen = 0;
   int tid_log[$];
   int start_log[$];

   function automatic logic [63:0] beat_data(int p, int id, int b);
      return {8'(p), 8'(8'hA5 ^ 8'(b)), 16'(id), 16'(b), 16'(p * 7919 + id * 31 + b * 3)};
   endfunction

   function automatic logic [7:0] beat_keep(int id, int b, int len);
      logic [7:0] k;
      k = 8'hFF;
      if (b == len - 1) k = 8'hFF >> (id % 8);
      return k;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add_frame(int p, int len);
      frame_t f;
      f.id  = 32'(next_id[p]);
      f.len = 32'(len);
      next_id[p]++;
      drv_q[p].push_back(f);
      exp_q[p].push_back(f);
      if (len > MAXW) begin
         exp_stb[p]++;
         exp_tc++;
      end
   endtask

   // Reference: every output frame is the oldest pending frame of port m_tid, cut to MAXW beats.
   task automatic monitor();
      frame_t       f;
      logic [77:0]  act;
      logic [77:0]  exp;
      bit           exp_last;
      bit           exp_trunc;
      if (!aresetn) begin
         in_frame = 1'b0;
         return;
      end
      for (int p = 0; p < NP; p++) if (trunc_stb[p]) stb_cnt[p]++;
      if (!(m_tvalid && m_tready)) return;
      if (!in_frame) begin
         cur_tid = int'(m_tid);
         if (cur_tid >= NP) begin
            tests++; fails++;
            $display("FAIL frame_tid: got tid=%0d, expected a port below %0d", cur_tid, NP);
            return;
         end
         if (exp_q[cur_tid].size() == 0) begin
            tests++; fails++;
            $display("FAIL frame_unexpected: got beat from tid=%0d, expected no pending frame there", cur_tid);
            return;
         end
         in_frame = 1'b1;
         cur_beat = 0;
         tid_log.push_back(cur_tid);
         start_log.push_back(cyc);
      end
      f = exp_q[cur_tid][0];
      exp_last  = (cur_beat == int'(f.len) - 1) || (cur_beat == MAXW - 1);
      exp_trunc = (cur_beat == MAXW - 1) && (int'(f.len) > MAXW);
      act = {m_tid, m_tdata, m_tkeep, m_tlast, m_trunc};
      exp = {PID'(cur_tid), beat_data(cur_tid, int'(f.id), cur_beat),
             beat_keep(int'(f.id), cur_beat, int'(f.len)), exp_last, exp_trunc};
      chk($sformatf("beat_p%0d_f%0d_b%0d", cur_tid, int'(f.id), cur_beat), 128'(act), 128'(exp));
      beats_seen++;
      cur_beat++;
      if (m_tlast || exp_last) begin
         void'(exp_q[cur_tid].pop_front());
         in_frame = 1'b0;
         frames_seen++;
      end
   endtask

   task automatic drive_update(logic [NP-1:0] acc);
      frame_t f;
      for (int p = 0; p < NP; p++) begin
         if (acc[p]) begin
            drv_beat[p]++;
            s_tvalid[p] = 1'b0;
            if (drv_beat[p] == drv_len[p]) drv_active[p] = 1'b0;
         end
         if (!drv_active[p] && drv_q[p].size() > 0) begin
            f = drv_q[p].pop_front();
            drv_active[p] = 1'b1;
            drv_id[p]     = int'(f.id);
            drv_len[p]    = int'(f.len);
            drv_beat[p]   = 0;
         end
         if (drv_active[p] && !s_tvalid[p] && (int'($urandom_range(99)) >= gap_pct)) begin
            s_tvalid[p]            = 1'b1;
            s_tdata[p*DW +: DW]    = beat_data(p, drv_id[p], drv_beat[p]);
            s_tkeep[p*DB +: DB]    = beat_keep(drv_id[p], drv_beat[p], drv_len[p]);
            s_tlast[p]             = (drv_beat[p] == drv_len[p] - 1);
         end
      end
      m_tready = (int'($urandom_range(99)) < rdy_pct);
   endtask

   task automatic step();
      logic [NP-1:0] acc;
      @(negedge clk);
      monitor();
      acc = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      cyc++;
      drive_update(acc);
   endtask

   function automatic bit all_idle();
      bit r;
      r = !in_frame;
      for (int p = 0; p < NP; p++) begin
         if (drv_active[p] || drv_q[p].size() != 0 || exp_q[p].size() != 0) r = 1'b0;
      end
      return r;
   endfunction

   task automatic wait_done(int limit, string name);
      int n;
      n = 0;
      while (!all_idle() && n < limit) begin
         step();
         n++;
      end
      tests++;
      if (!all_idle()) begin
         fails++;
         $display("FAIL %s_timeout: still busy after %0d cycles, expected all frames delivered", name, limit);
      end
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_s_tready"},    128'(s_tready),    128'(0));
      chk({tag, "_m_tvalid"},    128'(m_tvalid),    128'(0));
      chk({tag, "_m_tlast"},     128'(m_tlast),     128'(0));
      chk({tag, "_m_trunc"},     128'(m_trunc),     128'(0));
      chk({tag, "_m_tid"},       128'(m_tid),       128'(0));
      chk({tag, "_trunc_stb"},   128'(trunc_stb),   128'(0));
      chk({tag, "_trunc_count"}, 128'(trunc_count), 128'(0));
   endtask

   initial begin
      int n;
      int b0;
      int f0;
      int s0;
      int order1[4] = '{0, 1, 2, 3};
      int order2[4] = '{2, 1, 2, 2};
      int order6[3] = '{0, 1, 3};

      aresetn  = 1'b0;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      m_tready = 1'b0;

      repeat (3) step();
      check_reset_outputs("por");
      aresetn = 1'b1;

      // Four simultaneous 4-beat frames: strict 0,1,2,3 order, one idle cycle apart.
      gap_pct = 0; rdy_pct = 100; m_tready = 1'b1;
      tid_log.delete(); start_log.delete();
      b0 = beats_seen;
      for (int p = 0; p < NP; p++) add_frame(p, 4);
      wait_done(200, "rr4");
      chk("rr4_frames", 128'(tid_log.size()), 128'(4));
      chk("rr4_beats", 128'(beats_seen - b0), 128'(16));
      if (tid_log.size() == 4) begin
         for (int i = 0; i < 4; i++) chk($sformatf("rr4_order%0d", i), 128'(tid_log[i]), 128'(order1[i]));
         for (int i = 0; i < 3; i++) chk($sformatf("rr4_gap%0d", i), 128'(start_log[i+1] - start_log[i]), 128'(5));
      end

      // Port 2 streams back-to-back; port 1 joins mid-frame and must be served next.
      tid_log.delete();
      for (int k = 0; k < 3; k++) add_frame(2, 4);
      n = 0;
      while (tid_log.size() == 0 && n < 50) begin
         step();
         n++;
      end
      add_frame(1, 4);
      wait_done(300, "rr_alt");
      chk("rr_alt_frames", 128'(tid_log.size()), 128'(4));
      if (tid_log.size() == 4) begin
         for (int i = 0; i < 4; i++) chk($sformatf("rr_alt_order%0d", i), 128'(tid_log[i]), 128'(order2[i]));
      end

      // 12-beat frame on port 0 with an 8-beat limit.
      b0 = beats_seen; s0 = stb_cnt[0];
      add_frame(0, 12);
      wait_done(200, "trunc");
      chk("trunc_beats", 128'(beats_seen - b0), 128'(8));
      chk("trunc_stb0_pulses", 128'(stb_cnt[0] - s0), 128'(1));
      chk("trunc_count_1", 128'(trunc_count), 128'(1));

      // Exactly 8 beats on port 3: natural end, not a truncation.
      b0 = beats_seen; s0 = stb_cnt[3];
      add_frame(3, 8);
      wait_done(200, "exact");
      chk("exact_beats", 128'(beats_seen - b0), 128'(8));
      chk("exact_no_stb", 128'(stb_cnt[3] - s0), 128'(0));
      chk("exact_trunc_count", 128'(trunc_count), 128'(1));

      // Randomised gaps and backpressure across all ports.
      gap_pct = 30; rdy_pct = 50;
      f0 = frames_seen;
      for (int k = 0; k < 250; k++) begin
         for (int p = 0; p < NP; p++) add_frame(p, int'($urandom_range(1, 12)));
      end
      wait_done(70000, "random");
      chk("random_frames", 128'(frames_seen - f0), 128'(1000));
      chk("random_trunc_count", 128'(trunc_count), 128'(exp_tc));
      for (int p = 0; p < NP; p++) chk($sformatf("random_stb_p%0d", p), 128'(stb_cnt[p]), 128'(exp_stb[p]));

      // Reset in the middle of a port-1 frame.
      gap_pct = 0; rdy_pct = 100; m_tready = 1'b1;
      add_frame(1, 6);
      n = 0;
      while (!(in_frame && cur_tid == 1 && cur_beat >= 2) && n < 50) begin
         step();
         n++;
      end
      chk("rst_mid_pass_reached", 128'(in_frame && cur_tid == 1), 128'(1));
      aresetn = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      for (int p = 0; p < NP; p++) begin
         drv_q[p].delete();
         exp_q[p].delete();
         drv_active[p] = 1'b0;
      end
      s_tvalid = '0;
      in_frame = 1'b0;
      exp_tc   = 0;
      repeat (2) step();
      tid_log.delete();
      add_frame(0, 2);
      add_frame(1, 2);
      add_frame(3, 2);
      step();
      aresetn = 1'b1;
      wait_done(200, "post_rst");
      chk("post_rst_frames", 128'(tid_log.size()), 128'(3));
      if (tid_log.size() == 3) begin
         for (int i = 0; i < 3; i++) chk($sformatf("post_rst_order%0d", i), 128'(tid_log[i]), 128'(order6[i]));
      end
      chk("post_rst_trunc_count", 128'(trunc_count), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/p4_router_ingress_arbiter.md
Name: p4_router_ingress_arbiter

Overview:
- Frame-level round-robin arbiter directly downstream of the ingress port array adapter.
- Merges NUM_PORTS adapted ingress streams, already at the converged bus width, into one AXIS stream for the P4 parser.
- Tags each frame with its source port on m_tid.
- Enforces a maximum frame length: overlong frames are truncated and their remainder discarded.

Parameters:
- NUM_PORTS, 4, number of ingress streams; 2..16.
- DATA_BYTES, 8, converged bus width in bytes.
- PORT_ID_WIDTH, 4, width of m_tid; must satisfy 2**PORT_ID_WIDTH >= NUM_PORTS.
- MAX_FRAME_WORDS, 256, maximum beats per frame; the beat carrying the final permitted word is forced to tlast; must be >= 2.
- CNT_WIDTH, 32, width of trunc_count.

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset, deasserted synchronously to clk.
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tready  out  NUM_PORTS  per-port ready.
- s_tdata  in  NUM_PORTS*DATA_BYTES*8  port p data at [p*DATA_BYTES*8 +: DATA_BYTES*8].
- s_tkeep  in  NUM_PORTS*DATA_BYTES  port p keep at [p*DATA_BYTES +: DATA_BYTES].
- s_tlast  in  NUM_PORTS  per-port last.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  DATA_BYTES*8  output data.
- m_tkeep  out  DATA_BYTES  output keep.
- m_tlast  out  1  output last; includes forced truncation last.
- m_tid  out  PORT_ID_WIDTH  source port of the current frame, zero-extended.
- m_trunc  out  1  qualifies an m_tlast beat produced by truncation.
- trunc_stb  out  NUM_PORTS  one-cycle pulse on the port whose frame was truncated.
- trunc_count  out  CNT_WIDTH  total truncations; saturates at all-ones.

Behaviour:
- Reset values:
  - s_tready=0, m_tvalid=0, m_tlast=0, m_trunc=0, m_tid=0, trunc_stb=0, trunc_count=0.
  - State=IDLE; last_grant=NUM_PORTS-1, so port 0 has first priority; beat_cnt=0.
- State IDLE:
  - All s_tready=0, m_tvalid=0.
  - If any s_tvalid is set, register grant = first requesting port scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - Set last_grant=grant and m_tid=grant; go to PASS. Exactly one IDLE cycle between frames.
- State PASS:
  - Combinational pass-through of the granted port: m_tvalid=s_tvalid[g], s_tready[g]=m_tready, m_tdata/m_tkeep from port g; all other s_tready=0.
  - A beat is accepted when m_tvalid&&m_tready; beat_cnt increments per accepted beat.
  - Accepted beat with s_tlast=1: go to IDLE, beat_cnt=0.
  - When beat_cnt==MAX_FRAME_WORDS-1 and s_tlast=0:
    - Drive m_tlast=1 and m_trunc=1 on that beat.
    - On acceptance, pulse trunc_stb[g], increment trunc_count, go to DRAIN.
- State DRAIN:
  - m_tvalid=0, s_tready[g]=1; discard beats from port g.
  - Accepted beat with s_tlast=1: go to IDLE, beat_cnt=0.
- Non-granted ports are never blocked from holding tvalid. Arbitration never preempts a frame in progress.
- m_tid, m_trunc and m_tkeep are meaningful only while m_tvalid=1.
- A frame of exactly MAX_FRAME_WORDS beats ending in a natural tlast is not truncated: m_trunc=0, no count.
- Single-beat frame: PASS lasts one accepted beat.
- The granted port dropping tvalid mid-frame stalls the output; no timeout.
- Reset asserted mid-frame: immediate return to reset values. The downstream partial frame is not terminated; downstream resets on the same reset.

Optional Feature:
- Macro: P4_ROUTER_ING_ARB_OUTPUT_REG_EN.
- Defined:
  - A 2-entry skid register slice on the m_* outputs, including m_tid and m_trunc.
  - Adds 1 cycle of latency.
  - s_tready no longer combinationally depends on m_tready; full throughput is preserved.
  - State transitions use acceptance into the slice.
- Undefined: purely combinational PASS path as described above.

Test Plan:
- Ports 0..3 each present one 4-beat frame simultaneously -> output order ports 0,1,2,3; m_tid 0,1,2,3; one idle cycle between frames; 16 data beats total, bit-exact.
- Port 2 sends back-to-back frames while port 1 waits -> grants alternate 2,1,2; port 1 never waits more than one frame.
- MAX_FRAME_WORDS=8, port 0 sends a 12-beat frame -> 8 output beats, with beat 8 carrying m_tlast=1 and m_trunc=1. The remaining 4 beats are consumed with m_tvalid=0; trunc_stb[0] pulses once; trunc_count=1.
- Port 3 sends an exactly 8-beat frame (MAX=8) -> m_tlast on beat 8, m_trunc=0, trunc_count unchanged.
- Random m_tready (50%) and random s_tvalid gaps on 4 ports, 1000 frames -> scoreboard per-port data order matches; no beat duplicated or lost.
- aresetn asserted mid-PASS on port 1 -> all outputs at reset values that cycle; after release, the first grant goes to port 0 when ports 0 and 1 both request.
